writeback_unit: RTL

//  Writeback stage directly downstream of the ALU. Buffers ALU results in a 2-entry FIFO and commits
//  one result per clock into the 16x32 register file and CPSR flags. Serves two combinational read

---
 rtl/writeback_unit_if.sv | 24 ++
 rtl/writeback_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/writeback_unit_if.sv
// ALU-to-writeback result bus: one result per handshake, carrying up to two
// register writes plus the NZCV flags.
interface writeback_unit_if;
  logic        aluValid;
  logic        aluReady;
  logic [31:0] aluData1;
  logic [31:0] aluData2;
  logic [31:0] aluCpsr;
  logic        aluW;
  logic        aluW2;
  logic        aluS;
  logic [3:0]  aluRd;
  logic [3:0]  aluRd2;

  modport master (
    output aluValid, aluData1, aluData2, aluCpsr, aluW, aluW2, aluS, aluRd, aluRd2,
    input  aluReady
  );

  modport slave (
    input  aluValid, aluData1, aluData2, aluCpsr, aluW, aluW2, aluS, aluRd, aluRd2,
    output aluReady
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: queues ALU results in a small FIFO, retires one per clock
// into the register file and CPSR flags, and reports read-after-write hazards.
module writeback_unit #(
  parameter int DEPTH = 2,
  parameter int NREGS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  writeback_unit_if.slave        alu,
  input  logic                   stall,
  input  logic [3:0]             rdAddrA,
  output logic [31:0]            rdDataA,
  input  logic [3:0]             rdAddrB,
  output logic [31:0]            rdDataB,
  output logic                   hazardA,
  output logic                   hazardB,
  output logic [31:0]            cpsrOut,
  output logic                   pcWrite,
  output logic [31:0]            pcValue,
  output logic                   triggerOut
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] data1;
    logic [31:0] data2;
    logic [3:0]  flags;
    logic        w;
    logic        w2;
    logic        s;
    logic [3:0]  rd;
    logic [3:0]  rd2;
  } ResultEntry;

  ResultEntry        fifo [DEPTH];
  ResultEntry        newEntry;
  ResultEntry        headEntry;
  logic [PW-1:0]     headPtr;
  logic [PW-1:0]     tailPtr;
  logic [CW-1:0]     count;
  logic              started;
  logic              doAccept;
  logic              doCommit;
  logic [31:0]       regFile [NREGS];
  logic [3:0]        cpsrFlags;
  logic              writesPc;
  logic [31:0]       pcData;
  logic [PW-1:0]     slot;
  logic              unusedCpsrBits;

  // Low CPSR bits from the ALU carry nothing this stage keeps.
  assign unusedCpsrBits = ^alu.aluCpsr[27:0];

  // Ready comes only from registered state, so a full FIFO refuses even while it drains.
  assign alu.aluReady = started && (count != CW'(DEPTH));
  assign doAccept     = alu.aluValid && alu.aluReady;
  assign doCommit     = (count != '0) && !stall;
  assign headEntry    = fifo[headPtr];

  always_comb begin
    newEntry       = '0;
    newEntry.data1 = alu.aluData1;
    newEntry.data2 = alu.aluData2;
    newEntry.flags = alu.aluCpsr[31:28];
    newEntry.w     = alu.aluW;
    newEntry.w2    = alu.aluW2;
    newEntry.s     = alu.aluS;
    newEntry.rd    = alu.aluRd;
    newEntry.rd2   = alu.aluRd2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
      started <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo[i] <= '0;
      end
    end else begin
      started <= 1'b1;
      if (doAccept) begin
        fifo[tailPtr] <= newEntry;
        tailPtr       <= tailPtr + PW'(1);
      end
      if (doCommit) begin
        headPtr <= headPtr + PW'(1);
      end
      case ({doAccept, doCommit})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The secondary destination takes priority whenever both paths hit r15.
  assign writesPc = (headEntry.w && headEntry.rd == 4'd15) || (headEntry.w2 && headEntry.rd2 == 4'd15);
  assign pcData   = (headEntry.w2 && headEntry.rd2 == 4'd15) ? headEntry.data2 : headEntry.data1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regFile[i] <= '0;
      end
      cpsrFlags  <= '0;
      pcWrite    <= 1'b0;
      pcValue    <= '0;
      triggerOut <= 1'b0;
    end else begin
      pcWrite <= 1'b0;
      if (doCommit) begin
        if (headEntry.w) begin
          regFile[headEntry.rd] <= headEntry.data1;
        end
        if (headEntry.w2) begin
          regFile[headEntry.rd2] <= headEntry.data2;
        end
        if (headEntry.s) begin
          cpsrFlags <= headEntry.flags;
        end
        if (writesPc) begin
          pcWrite <= 1'b1;
          pcValue <= pcData;
        end
        triggerOut <= ~triggerOut;
      end
    end
  end

  assign rdDataA = regFile[rdAddrA];
  assign rdDataB = regFile[rdAddrB];
  assign cpsrOut = {cpsrFlags, 28'b0};

  // Walk the occupied slots from the head; the head still counts while it commits.
  always_comb begin
    hazardA = 1'b0;
    hazardB = 1'b0;
    slot    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = headPtr + PW'(i);
      if (CW'(i) < count) begin
        if ((fifo[slot].w && fifo[slot].rd == rdAddrA) || (fifo[slot].w2 && fifo[slot].rd2 == rdAddrA)) begin
          hazardA = 1'b1;
        end
        if ((fifo[slot].w && fifo[slot].rd == rdAddrB) || (fifo[slot].w2 && fifo[slot].rd2 == rdAddrB)) begin
          hazardB = 1'b1;
        end
      end
    end
  end

endmodule
